regs_param: RTL and testbench

REGS_PARAM -- requirements
Module: regs_param

---
 rtl/regs_pkg.sv | 18 +
 rtl/regs_sweep_ctrl.sv | 49 ++++
 rtl/regs_param.sv | 78 +++++++
 tb/tb_regs_param.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/regs_pkg.sv
// Shared definitions for the regs_param register file: default geometry and
// the sweep-clear state encoding.
package regs_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

  // Index of the last register the sweep visits.
  function automatic int last_index(input int depth);
    return depth - 1;
  endfunction

endpackage

// File: rtl/regs_sweep_ctrl.sv
// Sweep-clear controller: walks a pointer over every register once per
// clr_req, one register per clock, and reports busy while doing so.
module regs_sweep_ctrl
  import regs_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          clr_req,
  output logic          busy,
  output logic [AW-1:0] ptr,
  output logic          clr_en
);

  localparam logic [AW-1:0] LAST = AW'(last_index(DEPTH));

  sweep_state_e state;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= SWEEP;
            ptr   <= '0;
          end
        end
        SWEEP: begin
          // clr_req is deliberately ignored here: a running sweep is never
          // restarted or extended.
          ptr <= ptr + 1'b1;
          if (ptr == LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state == SWEEP);
  assign clr_en = (state == SWEEP);

endmodule

// File: rtl/regs_param.sv
// Parameterised 2-read/1-write register file with write-to-read bypass and a
// DEPTH-cycle sweep-clear. Define REGS_PARAM_ZERO_REG_EN to hardwire r0 to 0.
module regs_param
  import regs_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             we,
  input  logic [AW-1:0]    addr_w,
  input  logic [WIDTH-1:0] d,
  input  logic [AW-1:0]    addr_a,
  input  logic [AW-1:0]    addr_b,
  input  logic             clr_req,
  output logic [WIDTH-1:0] qa,
  output logic [WIDTH-1:0] qb,
  output logic             busy,
  output logic [DEPTH-1:0] valid
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;
  logic             clr_en;
  logic             wr_acc;

  regs_sweep_ctrl #(.DEPTH(DEPTH)) u_sweep (
    .clk     (clk),
    .clear_n (clear_n),
    .clr_req (clr_req),
    .busy    (busy),
    .ptr     (ptr),
    .clr_en  (clr_en)
  );

  // Gating with clear_n keeps the bypass from leaking d onto qa/qb in reset.
`ifdef REGS_PARAM_ZERO_REG_EN
  assign wr_acc = we && !busy && clear_n && (addr_w != '0);
`else
  assign wr_acc = we && !busy && clear_n;
`endif

  // NOTE: the storage is a flop array, not a RAM macro, so it takes the async
  // reset like any other state; only true SRAMs are left unreset.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      valid <= '0;
    end else if (clr_en) begin
      mem[ptr]   <= '0;
      valid[ptr] <= 1'b0;
    end else if (wr_acc) begin
      mem[addr_w]   <= d;
      valid[addr_w] <= 1'b1;
    end
  end

  // One shared read function guarantees both ports agree on the same address.
  function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] addr);
    logic [WIDTH-1:0] data;
    data = mem[addr];
    if (wr_acc && (addr_w == addr)) data = d;
`ifdef REGS_PARAM_ZERO_REG_EN
    if (addr == '0) data = '0;
`endif
    return data;
  endfunction

  // NOTE: each combinational output is assigned on every path through the
  // block, so no latch can be inferred.
  always_comb begin
    qa = read_port(addr_a);
    qb = read_port(addr_b);
  end

endmodule

// File: tb/tb_regs_param.sv
// Self-checking bench for regs_param (WIDTH=32, DEPTH=8): directed scenarios
// plus randomized traffic against a behavioural model of the register file.
module tb_regs_param;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
`ifdef REGS_PARAM_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             clear_n;
  logic             we;
  logic [AW-1:0]    addr_w;
  logic [WIDTH-1:0] d;
  logic [AW-1:0]    addr_a;
  logic [AW-1:0]    addr_b;
  logic             clr_req;
  logic [WIDTH-1:0] qa;
  logic [WIDTH-1:0] qb;
  logic             busy;
  logic [DEPTH-1:0] valid;

  regs_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .we      (we),
    .addr_w  (addr_w),
    .d       (d),
    .addr_a  (addr_a),
    .addr_b  (addr_b),
    .clr_req (clr_req),
    .qa      (qa),
    .qb      (qb),
    .busy    (busy),
    .valid   (valid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: array contents, written flags, and how many sweep edges remain.
  logic [WIDTH-1:0] m_regs [DEPTH];
  logic [DEPTH-1:0] m_valid;
  int               sweep_left;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] m_read(input logic [AW-1:0] a);
    if (ZERO && a == 0) return '0;
    if (clear_n && we && sweep_left == 0 && a == addr_w) return d;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
    m_valid    = '0;
    sweep_left = 0;
  endtask

  // Applies the effect of one rising edge to the model.
  task automatic model_edge();
    if (!clear_n) return;
    if (sweep_left > 0) begin
      m_regs[DEPTH - sweep_left]  = '0;
      m_valid[DEPTH - sweep_left] = 1'b0;
      sweep_left--;
    end else begin
      if (we && !(ZERO && addr_w == 0)) begin
        m_regs[addr_w]  = d;
        m_valid[addr_w] = 1'b1;
      end
      if (clr_req) sweep_left = DEPTH;
    end
  endtask

  task automatic compare_model();
    check("qa", qa, m_read(addr_a));
    check("qb", qb, m_read(addr_b));
    check("busy", busy, sweep_left > 0);
    check("valid", valid, m_valid);
  endtask

  task automatic drive(input logic w, input logic [AW-1:0] aw, input logic [WIDTH-1:0] dv,
                       input logic [AW-1:0] aa, input logic [AW-1:0] ab, input logic cr);
    @(negedge clk);
    clear_n = 1'b1;
    we      = w;
    addr_w  = aw;
    d       = dv;
    addr_a  = aa;
    addr_b  = ab;
    clr_req = cr;
    #2;
    compare_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
  endtask

  task automatic cyc(input logic w, input logic [AW-1:0] aw, input logic [WIDTH-1:0] dv,
                     input logic [AW-1:0] aa, input logic [AW-1:0] ab, input logic cr);
    drive(w, aw, dv, aa, ab, cr);
    tick();
  endtask

  // Asserts reset between edges and checks its effect is immediate.
  task automatic reset_dut();
    @(negedge clk);
    clear_n = 1'b0;
    #1;
    model_reset();
    compare_model();
    check("rst_busy", busy, 1'b0);
    check("rst_qa", qa, 32'h0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    clear_n = 1'b0;
    we = 1'b0; addr_w = '0; d = '0; addr_a = '0; addr_b = '0; clr_req = 1'b0;
    model_reset();
    #1;
    compare_model();
    check("reset_valid", valid, 8'h00);
    check("reset_qb", qb, 32'h0);

    // Write r3, read it back the next cycle.
    cyc(1'b1, 3'd3, 32'hDEADBEEF, 3'd0, 3'd1, 1'b0);
    drive(1'b0, 3'd0, 32'h0, 3'd3, 3'd0, 1'b0);
    check("r3_read", qa, 32'hDEADBEEF);
    check("r3_valid", valid, 8'h08);
    tick();

    // Bypass to both ports in the write cycle.
    drive(1'b1, 3'd5, 32'h12345678, 3'd5, 3'd5, 1'b0);
    check("bypass_qa", qa, 32'h12345678);
    check("bypass_qb", qb, 32'h12345678);
    tick();

    // Fill, sweep, and try to write r2 mid-sweep.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 3'(i), 32'(16 + i), 3'(i), 3'(7 - i), 1'b0);
    cyc(1'b0, 3'd0, 32'h0, 3'd2, 3'd7, 1'b1);
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      drive(i == 2, 3'd2, 32'hFF, 3'd2, 3'(i), 1'b0);
      if (busy) busy_cnt++;
      tick();
      if (!busy) break;
    end
    check("sweep_busy_cycles", busy_cnt, 8);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 3'd0, 32'h0, 3'(i), 3'(7 - i), 1'b0);
      check("swept_qa", qa, 32'h0);
      check("swept_valid", valid, 8'h00);
      tick();
    end

    // Reset in the middle of a sweep, then write on the first edge after release.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 3'(i), $urandom, 3'(i), 3'd6, 1'b0);
    cyc(1'b0, 3'd0, 32'h0, 3'd6, 3'd7, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 3'd0, 32'h0, 3'd6, 3'd7, 1'b0);
    reset_dut();
    cyc(1'b1, 3'd1, 32'hA5A5A5A5, 3'd0, 3'd1, 1'b0);
    drive(1'b0, 3'd0, 32'h0, 3'd1, 3'd1, 1'b0);
    check("post_reset_write", qa, 32'hA5A5A5A5);
    tick();

    // Register 0 behaviour depends on the build option.
    drive(1'b1, 3'd0, 32'hFFFFFFFF, 3'd0, 3'd0, 1'b0);
    check("r0_same_cycle", qa, ZERO ? 32'h0 : 32'hFFFFFFFF);
    tick();
    drive(1'b0, 3'd0, 32'h0, 3'd0, 3'd0, 1'b0);
    check("r0_next_cycle", qa, ZERO ? 32'h0 : 32'hFFFFFFFF);
    check("r0_valid", valid[0], !ZERO);
    tick();

    // clr_req together with a write; a second clr_req while busy is ignored.
    drive(1'b1, 3'd6, 32'h55, 3'd6, 3'd6, 1'b1);
    tick();
    drive(1'b0, 3'd0, 32'h0, 3'd6, 3'd6, 1'b0);
    check("r6_held_one_cycle", qa, 32'h55);
    check("busy_after_clr", busy, 1'b1);
    tick();
    busy_cnt = 1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 3'd0, 32'h0, 3'd6, 3'd6, i == 2);
      if (busy) busy_cnt++;
      tick();
      if (!busy) break;
    end
    check("reclr_busy_cycles", busy_cnt, 8);
    drive(1'b0, 3'd0, 32'h0, 3'd6, 3'd6, 1'b0);
    check("r6_cleared", qa, 32'h0);
    tick();

    // Randomized traffic, with occasional sweeps and resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) reset_dut();
      else cyc(1'($urandom), 3'($urandom), $urandom, 3'($urandom), 3'($urandom),
               $urandom_range(0, 19) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
